int_to_fp: RTL and testbench
============================

INT_TO_FP -- requirements
Module: int_to_fp

Interface
REQ-001 SHALL have parameter EXPWIDTH, default 8, result exponent width.
REQ-002 SHALL have parameter PRECISION, default 24, result significand width including hidden bit.
REQ-003 SHALL have parameter SOFT_THREAD, default 4, ctrl_vecmask width.
REQ-004 SHALL use one clock and a synchronous, active-high reset; all state updates on the rising edge of clk.
REQ-005 Ports SHALL be:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- op_i  in  3  bit2=double (unsupported), bit0=unsigned source
- a_i  in  64  integer operand; a_i[31:0] used
- rm_i  in  3  rounding mode
- in_valid_i  in  1  input valid
- in_ready_o  out  1  input ready
- out_valid_o  out  1  output valid
- out_ready_i  in  1  output ready
- result_o  out  64  converted value
- fflags_o  out  5  {NV,DZ,OF,UF,NX}
- ctrl_regindex_i/o  in/out  `REGIDX_WIDTH+`REGEXT_WIDTH  sideband
- ctrl_warpid_i/o  in/out  `DEPTH_WARP  sideband
- ctrl_vecmask_i/o  in/out  SOFT_THREAD  sideband
- ctrl_wvd_i/o, ctrl_wxd_i/o  in/out  1  sideband

Function
REQ-006 SHALL convert int32 (op_i[0]=0) or uint32 (op_i[0]=1) to an fp32 result in result_o[31:0], with result_o[63:32]=0.
REQ-007 When op_i[2]=1, result_o and fflags_o SHALL both be 0.
REQ-008 rm_i SHALL be decoded as 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; encodings 101-111 SHALL be treated as RNE.
REQ-009 Conversion sequence:
- take magnitude (two's-complement negate if signed and negative);
- leading-zero count;
- normalize to a 32-bit left-aligned value;
- keep the 24 MSBs plus guard bit and sticky bit;
- round per rm using the result sign;
- a rounding carry SHALL increment the exponent.
REQ-010 Exponent SHALL be 127+31-lzc; zero input SHALL give +0.0 (0x00000000) with fflags 0.
REQ-011 NX SHALL be set iff any discarded bit is nonzero; NV, DZ, OF and UF SHALL always be 0.
REQ-012 Pipeline SHALL have two stages (s1: registered inputs; s2: registered result), latency exactly 2 cycles with no stall.
REQ-013 in_ready_o SHALL equal !(valid_s1 && valid_s2 && !out_ready_i).
REQ-014 out_valid_o SHALL equal valid_s2.
REQ-015 s1 SHALL load when in_valid_i && in_ready_o.
REQ-016 s2 SHALL load when valid_s1 && !(valid_s2 && !out_ready_i).
REQ-017 Stalled stage registers SHALL hold their contents unchanged, and no transaction SHALL be dropped or duplicated.
REQ-018 Simultaneous output acceptance and input acceptance in one cycle SHALL both complete.

Reset
REQ-019 rst=1 SHALL clear valid_s1, valid_s2 and all data/sideband registers to 0, so out_valid_o=0, result_o=0 and fflags_o=0.
REQ-020 Reset mid-operation SHALL discard in-flight transactions.
REQ-021 in_ready_o SHALL be 1 from the first cycle after reset.

Configuration
REQ-022 Macro INT2FP_CTRLGEN_EN defined: ctrl_* ports exist and are carried through both stages aligned with their data.
REQ-023 INT2FP_CTRLGEN_EN undefined: ctrl_* ports and registers SHALL be absent, with function otherwise identical.

Structure
REQ-024 Rounding-mode encodings, op-bit positions, fflags bit indices and the fp32 bias constant SHALL live in the shared FPU package.
REQ-025 Combinational conversion SHALL be a sub-module int_to_fp_core (a, rm, op -> result, fflags); int_to_fp holds only the pipeline and handshake.

Verification
REQ-026 Signed 0x00000001 and 0xFFFFFFFF, RNE -> 0x3F800000 and 0xBF800000, fflags 0, out_valid exactly 2 cycles after acceptance.
REQ-027 Signed 0x7FFFFFFF:
- RNE -> 0x4F000000, NX=1;
- RTZ -> 0x4EFFFFFF, NX=1;
- signed 0x80000000 -> 0xCF000000, NX=0.
REQ-028 Unsigned 0xFFFFFFFF, RNE -> 0x4F800000, NX=1; unsigned 0x00000000 -> 0x00000000, fflags 0; op_i=3'b100 -> result 0, fflags 0.
REQ-029 Stall: hold out_ready_i=0 while issuing 3 back-to-back inputs; then:
- in_ready_o SHALL drop once both stages are full;
- the third input SHALL wait until accepted;
- on release, outputs SHALL appear in order with unchanged ctrl_warpid tags.
REQ-030 Reset asserted with both stages valid -> next cycle out_valid_o=0, result_o=0; the first post-reset input completes normally.

Source files
------------

// File: rtl/int_to_fp_pkg.sv
// Shared FPU constants for the int32/uint32 -> fp32 converter.
// Ctrl sideband width defaults apply only when INT2FP_CTRLGEN_EN is defined.
`ifdef INT2FP_CTRLGEN_EN
`ifndef REGIDX_WIDTH
`define REGIDX_WIDTH 5
`endif
`ifndef REGEXT_WIDTH
`define REGEXT_WIDTH 2
`endif
`ifndef DEPTH_WARP
`define DEPTH_WARP 3
`endif
`endif

package int_to_fp_pkg;

  typedef enum logic [2:0] {
    RmRne = 3'b000,
    RmRtz = 3'b001,
    RmRdn = 3'b010,
    RmRup = 3'b011,
    RmRmm = 3'b100
  } rm_e;

  localparam int unsigned OpDoubleBit   = 2;
  localparam int unsigned OpUnsignedBit = 0;

  localparam int unsigned FlagNv = 4;
  localparam int unsigned FlagDz = 3;
  localparam int unsigned FlagOf = 2;
  localparam int unsigned FlagUf = 1;
  localparam int unsigned FlagNx = 0;

  localparam int unsigned Fp32Bias = 127;

  // Leading-zero count; a zero input yields 0 and is handled by the caller.
  function automatic logic [4:0] lzc32(input logic [31:0] v);
    logic found;
    found = 1'b0;
    lzc32 = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      lzc32 = lzc32 + 5'd1;
      end
    end
  endfunction

endpackage

// File: rtl/int_to_fp_core.sv
// Combinational int32/uint32 -> floating-point conversion with rounding.
// Unaffected by INT2FP_CTRLGEN_EN.
module int_to_fp_core
  import int_to_fp_pkg::*;
#(
  parameter int unsigned EXPWIDTH  = 8,
  parameter int unsigned PRECISION = 24
) (
  input  logic [31:0] a,
  input  logic [2:0]  rm,
  input  logic [2:0]  op,
  output logic [63:0] result,
  output logic [4:0]  fflags
);

  localparam int unsigned DropW = 32 - PRECISION;
  localparam int unsigned Bias  = (EXPWIDTH == 8) ? Fp32Bias : (2 ** (EXPWIDTH - 1)) - 1;
  localparam logic [31:0] StickyMask = (32'd1 << (DropW - 1)) - 32'd1;

  logic                  sign;
  logic [31:0]           mag;
  logic [4:0]            lzc;
  logic [31:0]           norm;
  logic [PRECISION-1:0]  mant;
  logic                  guard;
  logic                  sticky;
  logic                  round_up;
  logic [PRECISION:0]    mant_r;
  logic                  carry;
  logic [PRECISION-2:0]  frac;
  logic [EXPWIDTH-1:0]   expo;
  logic                  unused_op;

  assign unused_op = op[1];

  always_comb begin
    sign     = ~op[OpUnsignedBit] & a[31];
    mag      = sign ? (~a + 32'd1) : a;
    lzc      = lzc32(mag);
    norm     = mag << lzc;
    mant     = norm[31 -: PRECISION];
    guard    = norm[DropW-1];
    sticky   = |(norm & StickyMask);
    round_up = 1'b0;

    // Directed modes round the magnitude, so their direction depends on sign.
    case (rm)
      RmRtz:   round_up = 1'b0;
      RmRdn:   round_up = sign & (guard | sticky);
      RmRup:   round_up = ~sign & (guard | sticky);
      RmRmm:   round_up = guard;
      default: round_up = guard & (sticky | mant[0]);
    endcase

    mant_r = {1'b0, mant} + (PRECISION + 1)'(round_up);
    carry  = mant_r[PRECISION];
    frac   = carry ? mant_r[PRECISION-1:1] : mant_r[PRECISION-2:0];
    expo   = EXPWIDTH'(Bias + 32'd31 - 32'(lzc) + 32'(carry));

    result = '0;
    fflags = '0;
    if (!op[OpDoubleBit] && (mag != 32'd0)) begin
      result[EXPWIDTH+PRECISION-1:0] = {sign, expo, frac};
      fflags[FlagNx]                 = guard | sticky;
    end
  end

endmodule

// File: rtl/int_to_fp.sv
// Two-stage pipelined int -> fp32 converter with valid/ready handshake.
// Define INT2FP_CTRLGEN_EN to carry ctrl_* sideband through the pipeline.
module int_to_fp
  import int_to_fp_pkg::*;
#(
  parameter int unsigned EXPWIDTH    = 8,
  parameter int unsigned PRECISION   = 24,
  parameter int unsigned SOFT_THREAD = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [2:0]                             op_i,
  input  logic [63:0]                            a_i,
  input  logic [2:0]                             rm_i,
  input  logic                                   in_valid_i,
  output logic                                   in_ready_o,
  output logic                                   out_valid_o,
  input  logic                                   out_ready_i,
`ifdef INT2FP_CTRLGEN_EN
  input  logic [`REGIDX_WIDTH+`REGEXT_WIDTH-1:0] ctrl_regindex_i,
  input  logic [`DEPTH_WARP-1:0]                 ctrl_warpid_i,
  input  logic [SOFT_THREAD-1:0]                 ctrl_vecmask_i,
  input  logic                                   ctrl_wvd_i,
  input  logic                                   ctrl_wxd_i,
  output logic [`REGIDX_WIDTH+`REGEXT_WIDTH-1:0] ctrl_regindex_o,
  output logic [`DEPTH_WARP-1:0]                 ctrl_warpid_o,
  output logic [SOFT_THREAD-1:0]                 ctrl_vecmask_o,
  output logic                                   ctrl_wvd_o,
  output logic                                   ctrl_wxd_o,
`endif
  output logic [63:0]                            result_o,
  output logic [4:0]                             fflags_o
);

`ifdef INT2FP_CTRLGEN_EN
  typedef struct packed {
    logic [`REGIDX_WIDTH+`REGEXT_WIDTH-1:0] regindex;
    logic [`DEPTH_WARP-1:0]                 warpid;
    logic [SOFT_THREAD-1:0]                 vecmask;
    logic                                   wvd;
    logic                                   wxd;
  } ctrl_t;

  ctrl_t ctrl_in, ctrl_s1, ctrl_s2;

  assign ctrl_in = '{regindex: ctrl_regindex_i, warpid: ctrl_warpid_i,
                     vecmask: ctrl_vecmask_i, wvd: ctrl_wvd_i, wxd: ctrl_wxd_i};
  assign ctrl_regindex_o = ctrl_s2.regindex;
  assign ctrl_warpid_o   = ctrl_s2.warpid;
  assign ctrl_vecmask_o  = ctrl_s2.vecmask;
  assign ctrl_wvd_o      = ctrl_s2.wvd;
  assign ctrl_wxd_o      = ctrl_s2.wxd;
`else
  localparam int unsigned unused_soft_thread = SOFT_THREAD;
`endif

  logic        valid_s1, valid_s2;
  logic [31:0] a_s1;
  logic [2:0]  op_s1, rm_s1;
  logic [63:0] result_s2, core_result;
  logic [4:0]  fflags_s2, core_fflags;
  logic        stall_s2, load_s1, load_s2;
  logic [31:0] unused_a_hi;

  assign unused_a_hi = a_i[63:32];

  assign stall_s2    = valid_s2 & ~out_ready_i;
  assign in_ready_o  = ~(valid_s1 & stall_s2);
  assign load_s1     = in_valid_i & in_ready_o;
  assign load_s2     = valid_s1 & ~stall_s2;
  assign out_valid_o = valid_s2;
  assign result_o    = result_s2;
  assign fflags_o    = fflags_s2;

  int_to_fp_core #(
    .EXPWIDTH (EXPWIDTH),
    .PRECISION(PRECISION)
  ) u_core (
    .a     (a_s1),
    .rm    (rm_s1),
    .op    (op_s1),
    .result(core_result),
    .fflags(core_fflags)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_s1  <= 1'b0;
      valid_s2  <= 1'b0;
      a_s1      <= '0;
      op_s1     <= '0;
      rm_s1     <= '0;
      result_s2 <= '0;
      fflags_s2 <= '0;
`ifdef INT2FP_CTRLGEN_EN
      ctrl_s1   <= '0;
      ctrl_s2   <= '0;
`endif
    end else begin
      if (load_s1) begin
        valid_s1 <= 1'b1;
        a_s1     <= a_i[31:0];
        op_s1    <= op_i;
        rm_s1    <= rm_i;
`ifdef INT2FP_CTRLGEN_EN
        ctrl_s1  <= ctrl_in;
`endif
      end else if (load_s2) begin
        valid_s1 <= 1'b0;
      end

      if (load_s2) begin
        valid_s2  <= 1'b1;
        result_s2 <= core_result;
        fflags_s2 <= core_fflags;
`ifdef INT2FP_CTRLGEN_EN
        ctrl_s2   <= ctrl_s1;
`endif
      end else if (out_ready_i) begin
        valid_s2 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_int_to_fp.sv
// Directed-vector bench for int_to_fp: conversions, latency, stall and reset.
// Sideband tags are checked only when INT2FP_CTRLGEN_EN is defined.
module tb_int_to_fp;
  import int_to_fp_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  op_i;
  logic [63:0] a_i;
  logic [2:0]  rm_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [63:0] result_o;
  logic [4:0]  fflags_o;

`ifdef INT2FP_CTRLGEN_EN
  logic [`REGIDX_WIDTH+`REGEXT_WIDTH-1:0] ctrl_regindex_i, ctrl_regindex_o;
  logic [`DEPTH_WARP-1:0]                 ctrl_warpid_i, ctrl_warpid_o;
  logic [3:0]                             ctrl_vecmask_i, ctrl_vecmask_o;
  logic                                   ctrl_wvd_i, ctrl_wvd_o, ctrl_wxd_i, ctrl_wxd_o;
`endif

  always #5 clk = ~clk;

  int_to_fp #(
    .EXPWIDTH   (8),
    .PRECISION  (24),
    .SOFT_THREAD(4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .op_i           (op_i),
    .a_i            (a_i),
    .rm_i           (rm_i),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
`ifdef INT2FP_CTRLGEN_EN
    .ctrl_regindex_i(ctrl_regindex_i),
    .ctrl_warpid_i  (ctrl_warpid_i),
    .ctrl_vecmask_i (ctrl_vecmask_i),
    .ctrl_wvd_i     (ctrl_wvd_i),
    .ctrl_wxd_i     (ctrl_wxd_i),
    .ctrl_regindex_o(ctrl_regindex_o),
    .ctrl_warpid_o  (ctrl_warpid_o),
    .ctrl_vecmask_o (ctrl_vecmask_o),
    .ctrl_wvd_o     (ctrl_wvd_o),
    .ctrl_wxd_o     (ctrl_wxd_o),
`endif
    .result_o       (result_o),
    .fflags_o       (fflags_o)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [2:0]  rm;
    logic [31:0] res;
    logic [4:0]  ff;
  } vec_t;

  localparam int NumVecs = 18;
  vec_t vecs[NumVecs];

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  task automatic set_warp(input int t);
`ifdef INT2FP_CTRLGEN_EN
    ctrl_warpid_i = t[`DEPTH_WARP-1:0];
`endif
  endtask

  // Issue one vector and check 2-cycle latency plus the converted value.
  task automatic run_vec(input int i);
    @(negedge clk);
    op_i        = vecs[i].op;
    a_i         = {32'hDEAD_BEEF, vecs[i].a};
    rm_i        = vecs[i].rm;
    in_valid_i  = 1'b1;
    out_ready_i = 1'b1;
    check($sformatf("v%0d_in_ready", i), 64'(in_ready_o), 64'd1);
    @(negedge clk);
    in_valid_i = 1'b0;
    check($sformatf("v%0d_valid_c1", i), 64'(out_valid_o), 64'd0);
    @(negedge clk);
    check($sformatf("v%0d_valid_c2", i), 64'(out_valid_o), 64'd1);
    check($sformatf("v%0d_result", i), result_o, {32'd0, vecs[i].res});
    check($sformatf("v%0d_fflags", i), 64'(fflags_o), 64'(vecs[i].ff));
  endtask

  logic [31:0] got_res[3];
  int          got_tag[3];
  int          got;
  logic        fire_in, fire_out;

  initial begin
    vecs[0]  = '{3'b000, 32'h0000_0001, 3'b000, 32'h3F80_0000, 5'h00};
    vecs[1]  = '{3'b000, 32'hFFFF_FFFF, 3'b000, 32'hBF80_0000, 5'h00};
    vecs[2]  = '{3'b000, 32'h7FFF_FFFF, 3'b000, 32'h4F00_0000, 5'h01};
    vecs[3]  = '{3'b000, 32'h7FFF_FFFF, 3'b001, 32'h4EFF_FFFF, 5'h01};
    vecs[4]  = '{3'b000, 32'h8000_0000, 3'b000, 32'hCF00_0000, 5'h00};
    vecs[5]  = '{3'b001, 32'hFFFF_FFFF, 3'b000, 32'h4F80_0000, 5'h01};
    vecs[6]  = '{3'b001, 32'h0000_0000, 3'b000, 32'h0000_0000, 5'h00};
    vecs[7]  = '{3'b100, 32'h0000_0001, 3'b000, 32'h0000_0000, 5'h00};
    vecs[8]  = '{3'b000, 32'h7FFF_FFFF, 3'b010, 32'h4EFF_FFFF, 5'h01};
    vecs[9]  = '{3'b000, 32'h7FFF_FFFF, 3'b011, 32'h4F00_0000, 5'h01};
    vecs[10] = '{3'b000, 32'h8000_0001, 3'b011, 32'hCEFF_FFFF, 5'h01};
    vecs[11] = '{3'b000, 32'h8000_0001, 3'b010, 32'hCF00_0000, 5'h01};
    vecs[12] = '{3'b000, 32'h0100_0001, 3'b000, 32'h4B80_0000, 5'h01};
    vecs[13] = '{3'b000, 32'h0100_0001, 3'b100, 32'h4B80_0001, 5'h01};
    vecs[14] = '{3'b000, 32'h0100_0001, 3'b101, 32'h4B80_0000, 5'h01};
    vecs[15] = '{3'b000, 32'h0100_0003, 3'b000, 32'h4B80_0002, 5'h01};
    vecs[16] = '{3'b000, 32'hFFFF_FFF6, 3'b000, 32'hC120_0000, 5'h00};
    vecs[17] = '{3'b000, 32'h0000_0005, 3'b000, 32'h40A0_0000, 5'h00};

    rst         = 1'b1;
    op_i        = '0;
    a_i         = '0;
    rm_i        = '0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
`ifdef INT2FP_CTRLGEN_EN
    ctrl_regindex_i = '0;
    ctrl_warpid_i   = '0;
    ctrl_vecmask_i  = '0;
    ctrl_wvd_i      = 1'b0;
    ctrl_wxd_i      = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_out_valid", 64'(out_valid_o), 64'd0);
    check("rst_result", result_o, 64'd0);
    check("rst_fflags", 64'(fflags_o), 64'd0);
    check("rst_in_ready", 64'(in_ready_o), 64'd1);

    for (int i = 0; i < NumVecs; i++) run_vec(i);

    // Stall: three back-to-back inputs with the output blocked.
    @(negedge clk);
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    op_i        = 3'b000;
    rm_i        = 3'b000;
    a_i         = 64'd1;
    set_warp(1);
    @(negedge clk);
    a_i = 64'd2;
    set_warp(2);
    @(negedge clk);
    check("stall_ready_drop", 64'(in_ready_o), 64'd0);
    a_i = 64'd3;
    set_warp(3);
    repeat (3) @(negedge clk);
    check("stall_ready_held", 64'(in_ready_o), 64'd0);
    check("stall_out_valid", 64'(out_valid_o), 64'd1);
    check("stall_out_held", result_o, 64'h3F80_0000);

    out_ready_i = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 3; c++) begin
      fire_out = out_valid_o;
      fire_in  = in_valid_i & in_ready_o;
      if (fire_out) begin
        got_res[got] = result_o[31:0];
`ifdef INT2FP_CTRLGEN_EN
        got_tag[got] = int'(ctrl_warpid_o);
`else
        got_tag[got] = got + 1;
`endif
        got++;
      end
      @(negedge clk);
      if (fire_in) in_valid_i = 1'b0;
    end
    in_valid_i = 1'b0;
    check("drain_count", 64'(got), 64'd3);
    if (got == 3) begin
      check("drain_res0", 64'(got_res[0]), 64'h3F80_0000);
      check("drain_res1", 64'(got_res[1]), 64'h4000_0000);
      check("drain_res2", 64'(got_res[2]), 64'h4040_0000);
`ifdef INT2FP_CTRLGEN_EN
      for (int k = 0; k < 3; k++)
        check($sformatf("drain_tag%0d", k), 64'(got_tag[k]), 64'(k + 1));
`endif
    end
    repeat (3) @(negedge clk);
    check("drain_no_dup", 64'(out_valid_o), 64'd0);

    // Reset with both stages holding transactions.
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    a_i         = 64'd7;
    set_warp(5);
    @(negedge clk);
    a_i = 64'd9;
    @(negedge clk);
    in_valid_i = 1'b0;
    check("mid_full_valid", 64'(out_valid_o), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_valid", 64'(out_valid_o), 64'd0);
    check("mid_rst_result", result_o, 64'd0);
    check("mid_rst_fflags", 64'(fflags_o), 64'd0);
    check("mid_rst_ready", 64'(in_ready_o), 64'd1);
`ifdef INT2FP_CTRLGEN_EN
    check("mid_rst_warpid", 64'(ctrl_warpid_o), 64'd0);
`endif
    run_vec(17);
    @(negedge clk);
    check("post_rst_drained", 64'(out_valid_o), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
